apb_master_bridge: RTL

CPU-side APB4 master that turns single-beat CPU load/store requests (valid/ready request, one-cycle response pulse) into APB4 SETUP/ACCESS sequences on the master port of `apb_interconnect`. It sits directly upstream of the interconnect. It owns the APB phase state machine, misalignment rejection and a hung-slave timeout watchdog.

---
 rtl/apb_master_bridge.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single-beat CPU load/store requests into APB4
// SETUP/ACCESS sequences, rejecting misaligned addresses and aborting hung slaves.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timeout_flag,
    input  logic        timeout_clr,
    output logic [31:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    input  logic        m_pready,
    input  logic [31:0] m_prdata,
    input  logic        m_pslverr
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    // Next-state and registered-output logic; response regs only hold data in RESP.
    always_comb begin
        state_d        = state_q;
        paddr_d        = paddr_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        pwrite_d       = pwrite_q;
        pwdata_d       = pwdata_q;
        pstrb_d        = pstrb_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_err_d      = 1'b0;
        wait_cnt_d     = wait_cnt_q;
        timeout_flag_d = timeout_clr ? 1'b0 : timeout_flag_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_addr[1:0] == 2'b00) begin
                        paddr_d    = req_addr;
                        pwrite_d   = req_write;
                        pwdata_d   = req_wdata;
                        pstrb_d    = req_write ? req_wstrb : STRB_W'(0);
                        psel_d     = 1'b1;
                        penable_d  = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = S_SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? DATA_W'(0) : m_prdata;
                    rsp_err_d   = m_pslverr;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (WDOG_EN && (wait_cnt_inc == CNT_LIMIT)) begin
                        psel_d         = 1'b0;
                        penable_d      = 1'b0;
                        timeout_flag_d = 1'b1;
                        rsp_valid_d    = 1'b1;
                        rsp_err_d      = 1'b1;
                        state_d        = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q        <= S_IDLE;
            paddr_q        <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            pwdata_q       <= '0;
            pstrb_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            timeout_flag_q <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            paddr_q        <= paddr_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            timeout_flag_q <= timeout_flag_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign timeout_flag = timeout_flag_q;
    assign m_paddr      = paddr_q;
    assign m_psel       = psel_q;
    assign m_penable    = penable_q;
    assign m_pwrite     = pwrite_q;
    assign m_pwdata     = pwdata_q;
    assign m_pstrb      = pstrb_q;

endmodule
